// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the alu issue stage: opcodes, datapath width and
// the per-entry result/flag record carried through the result FIFO.
package alu_issue_stage_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_XOR  = 3'd2,
    OP_SLT  = 3'd3,
    OP_AND  = 3'd4,
    OP_NAND = 3'd5,
    OP_NOR  = 3'd6,
    OP_OR   = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic             ovf;
    logic             zero;
    logic             neg;
  } res_entry_t;

  // Only arithmetic ops produce a meaningful overflow from the alu.
  function automatic logic op_has_ovf(input logic [2:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_ADD, OP_SUB: r = 1'b1;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_stage_result_fifo.sv
// Small circular result FIFO; head is presented straight from storage so the
// consumer sees no combinational path from the producer side.
module alu_issue_stage_result_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 39
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         valid,
  output logic         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign valid = (count_q != '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && valid;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage around an external combinational alu: registers operands that
// drive the alu, queues results with flags, and tracks sticky overflow.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_op,
  input  logic signed [ALU_W-1:0] in_a,
  input  logic signed [ALU_W-1:0] in_b,
  input  logic [TAG_W-1:0]        in_tag,
  output logic [2:0]              alu_op,
  output logic [ALU_W-1:0]        alu_a,
  output logic [ALU_W-1:0]        alu_b,
  input  logic [ALU_W-1:0]        alu_out,
  input  logic                    alu_ovf,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ALU_W-1:0]        out_result,
  output logic                    out_ovf,
  output logic                    out_zero,
  output logic                    out_neg,
  output logic [TAG_W-1:0]        out_tag,
  input  logic                    clr_sticky,
  output logic                    ovf_sticky,
  output logic [7:0]              ovf_count
);

  localparam int ENT_W = $bits(res_entry_t) + TAG_W;

  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic                    vld_p1_q, vld_p1_d;
  logic [2:0]              op_p1_q, op_p1_d;
  logic signed [ALU_W-1:0] a_p1_q, a_p1_d;
  logic signed [ALU_W-1:0] b_p1_q, b_p1_d;
  logic [TAG_W-1:0]        tag_p1_q, tag_p1_d;
  logic                    ovf_sticky_q, ovf_sticky_d;
  logic [7:0]              ovf_count_q, ovf_count_d;

  logic             fifo_valid, fifo_full;
  logic             pop, drain, accept, push_ovf;
  res_entry_t       push_ent, head_ent;
  logic [ENT_W-1:0] fifo_rdata;

  assign pop      = fifo_valid && out_ready;
  assign drain    = vld_p1_q && (!fifo_full || pop);
  assign in_ready = !vld_p1_q || drain;
  assign accept   = in_valid && in_ready;

  assign alu_op = op_p1_q;
  assign alu_a  = a_p1_q;
  assign alu_b  = b_p1_q;

  // Stage 1: operand register feeding the alu
  always_comb begin
    vld_p1_d = vld_p1_q;
    op_p1_d  = op_p1_q;
    a_p1_d   = a_p1_q;
    b_p1_d   = b_p1_q;
    tag_p1_d = tag_p1_q;
    if (drain) vld_p1_d = 1'b0;
    if (accept) begin
      vld_p1_d = 1'b1;
      op_p1_d  = in_op;
      a_p1_d   = in_a;
      b_p1_d   = in_b;
      tag_p1_d = in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      op_p1_q  <= '0;
      a_p1_q   <= '0;
      b_p1_q   <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      op_p1_q  <= op_p1_d;
      a_p1_q   <= a_p1_d;
      b_p1_q   <= b_p1_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_p1_q <= tag_p1_d;
  end

  // Stage 2: capture alu result and flags into the result FIFO
  always_comb begin
    push_ent.result = alu_out;
    push_ent.ovf    = alu_ovf && op_has_ovf(op_p1_q);
    push_ent.zero   = (alu_out == '0);
    push_ent.neg    = alu_out[ALU_W-1];
  end

  alu_issue_stage_result_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_result_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (drain),
    .wdata ({push_ent, tag_p1_q}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .valid (fifo_valid),
    .full  (fifo_full)
  );

  assign {head_ent, out_tag} = fifo_rdata;
  assign out_valid  = fifo_valid;
  assign out_result = head_ent.result;
  assign out_ovf    = head_ent.ovf;
  assign out_zero   = head_ent.zero;
  assign out_neg    = head_ent.neg;

  // A coincident overflow push beats the clear, restarting the count at one.
  assign push_ovf = drain && push_ent.ovf;

  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    ovf_count_d  = ovf_count_q;
    if (clr_sticky) begin
      ovf_sticky_d = 1'b0;
      ovf_count_d  = 8'd0;
    end
    if (push_ovf) begin
      ovf_sticky_d = 1'b1;
      ovf_count_d  = clr_sticky ? 8'd1 : sat_inc8(ovf_count_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky_q <= 1'b0;
      ovf_count_q  <= 8'd0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;
  assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural alu stub on alu_*.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        alu_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_ovf;
  logic        out_zero;
  logic        out_neg;
  logic [3:0]  out_tag;
  logic        clr_sticky;
  logic        ovf_sticky;
  logic [7:0]  ovf_count;

  logic        force_ovf;
  int          checks;
  int          errors;

  alu_issue_stage #(.DEPTH(2), .TAG_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_ovf    (alu_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_tag    (out_tag),
    .clr_sticky (clr_sticky),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Alu stub; force_ovf lets non-arithmetic ops present a spurious overflow.
  logic [31:0] sum_w, dif_w;
  always_comb begin
    sum_w   = alu_a + alu_b;
    dif_w   = alu_a - alu_b;
    alu_out = '0;
    alu_ovf = force_ovf;
    case (alu_op)
      3'd0: begin
        alu_out = sum_w;
        alu_ovf = force_ovf | ((alu_a[31] == alu_b[31]) && (sum_w[31] != alu_a[31]));
      end
      3'd1: begin
        alu_out = dif_w;
        alu_ovf = force_ovf | ((alu_a[31] != alu_b[31]) && (dif_w[31] != alu_a[31]));
      end
      3'd2: alu_out = alu_a ^ alu_b;
      3'd3: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      3'd4: alu_out = alu_a & alu_b;
      3'd5: alu_out = ~(alu_a & alu_b);
      3'd6: alu_out = ~(alu_a | alu_b);
      default: alu_out = alu_a | alu_b;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int exp_tag;
    int n;
    int cyc;
    checks     = 0;
    errors     = 0;
    force_ovf  = 1'b0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_op      = '0;
    in_a       = '0;
    in_b       = '0;
    in_tag     = '0;
    out_ready  = 1'b1;
    clr_sticky = 1'b0;

    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    chk("rst_count", 32'(ovf_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: negative ADD result, two-edge latency
    send(3'd0, 32'(-2147483000), 32'd1, 4'd3);
    chk("t1_alu_a", alu_a, 32'(-2147483000));
    chk("t1_not_yet", 32'(out_valid), 32'd0);
    step();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_result", out_result, 32'(-2147482999));
    chk("t1_ovf", 32'(out_ovf), 32'd0);
    chk("t1_zero", 32'(out_zero), 32'd0);
    chk("t1_neg", 32'(out_neg), 32'd1);
    chk("t1_tag", 32'(out_tag), 32'd3);
    step();
    chk("t1_popped", 32'(out_valid), 32'd0);

    // 2: ADD overflow, then SUB to zero
    send(3'd0, 32'h7FFF_FFFF, 32'd1, 4'd4);
    step();
    chk("t2_result", out_result, 32'h8000_0000);
    chk("t2_ovf", 32'(out_ovf), 32'd1);
    chk("t2_sticky", 32'(ovf_sticky), 32'd1);
    chk("t2_count", 32'(ovf_count), 32'd1);
    step();
    send(3'd1, 32'd5, 32'd5, 4'd5);
    step();
    chk("t2_sub_result", out_result, 32'd0);
    chk("t2_sub_zero", 32'(out_zero), 32'd1);
    chk("t2_sub_ovf", 32'(out_ovf), 32'd0);
    chk("t2_sub_neg", 32'(out_neg), 32'd0);
    chk("t2_sub_tag", 32'(out_tag), 32'd5);
    step();

    // 3: SLT with a spurious alu overflow is masked
    force_ovf = 1'b1;
    send(3'd3, 32'h8000_0000, 32'd1, 4'd6);
    step();
    chk("t3_result", out_result, 32'd1);
    chk("t3_ovf_masked", 32'(out_ovf), 32'd0);
    chk("t3_count", 32'(ovf_count), 32'd1);
    force_ovf = 1'b0;
    step();

    // 4: backpressure with four back-to-back requests
    out_ready = 1'b0;
    for (int t = 8; t < 11; t++) begin
      in_valid = 1'b1;
      in_op    = 3'd0;
      in_a     = 32'(t);
      in_b     = 32'd100;
      in_tag   = 4'(t);
      step();
    end
    in_a   = 32'd11;
    in_tag = 4'd11;
    #1;
    chk("t4_in_ready_low", 32'(in_ready), 32'd0);
    chk("t4_alu_a_held", alu_a, 32'd10);
    step();
    step();
    chk("t4_alu_a_stable", alu_a, 32'd10);
    chk("t4_still_stalled", 32'(in_ready), 32'd0);
    chk("t4_head_tag", 32'(out_tag), 32'd8);
    out_ready = 1'b1;
    #1;
    chk("t4_ready_on_pop", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    exp_tag  = 9;
    cyc      = 0;
    while (exp_tag < 12 && cyc < 20) begin
      if (out_valid) begin
        chk("t4_order_tag", 32'(out_tag), 32'(exp_tag));
        chk("t4_order_result", out_result, 32'(exp_tag + 100));
        exp_tag++;
      end
      step();
      cyc++;
    end
    chk("t4_all_emerged", 32'(exp_tag), 32'd12);
    chk("t4_empty", 32'(out_valid), 32'd0);

    // 5: saturation, clear-vs-set priority, plain clear
    in_valid = 1'b1;
    in_op    = 3'd0;
    in_a     = 32'h7FFF_FFFF;
    in_b     = 32'd1;
    in_tag   = 4'd1;
    n        = 0;
    cyc      = 0;
    while (n < 300 && cyc < 1000) begin
      if (in_ready) n++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("t5_accepted", 32'(n), 32'd300);
    step();
    step();
    step();
    chk("t5_sat_count", 32'(ovf_count), 32'd255);
    chk("t5_sat_sticky", 32'(ovf_sticky), 32'd1);
    send(3'd0, 32'h7FFF_FFFF, 32'd1, 4'd2);
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("t5_clr_set_sticky", 32'(ovf_sticky), 32'd1);
    chk("t5_clr_set_count", 32'(ovf_count), 32'd1);
    step();
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("t5_clr_sticky", 32'(ovf_sticky), 32'd0);
    chk("t5_clr_count", 32'(ovf_count), 32'd0);

    // 6: asynchronous reset mid-cycle with a full pipeline
    out_ready = 1'b0;
    for (int t = 1; t < 4; t++) begin
      in_valid = 1'b1;
      in_op    = 3'd0;
      in_a     = 32'(t);
      in_b     = 32'd1;
      in_tag   = 4'(t);
      step();
    end
    in_valid = 1'b0;
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    chk("t6_pre_stall", 32'(in_ready), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd1);
    chk("t6_rst_alu_a", alu_a, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    send(3'd0, 32'd10, 32'd20, 4'd6);
    step();
    chk("t6_post_valid", 32'(out_valid), 32'd1);
    chk("t6_post_result", out_result, 32'd30);
    chk("t6_post_tag", 32'(out_tag), 32'd6);
    step();
    chk("t6_post_empty", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Pipeline wrapper around the combinational 32-bit alu. It accepts operation requests over a valid/ready handshake and registers the operands, which drive the alu directly. It captures the alu result, overflow, zero and negative flags into a small output FIFO and keeps sticky overflow status. It sits between the instruction/test sequencer and any result consumer, so a multi-cycle datapath can use the alu at one operation per cycle with backpressure.

Parameters:
DEPTH, 2, result FIFO entries; power of two, ≥2
TAG_W, 4, width of the request tag carried alongside each operation

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  stage can accept a request this cycle
in_op  in  3  opcode: ADD=0 SUB=1 XOR=2 SLT=3 AND=4 NAND=5 NOR=6 OR=7
in_a  in  32  operand a (signed)
in_b  in  32  operand b (signed)
in_tag  in  TAG_W  request tag
alu_op  out  3  registered opcode to alu operation input
alu_a  out  32  registered operand to alu a
alu_b  out  32  registered operand to alu b
alu_out  in  32  alu result (combinational from alu_*)
alu_ovf  in  1  alu overflow
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer takes head
out_result  out  32  head result
out_ovf  out  1  head overflow (masked)
out_zero  out  1  head result==0
out_neg  out  1  head result[31]
out_tag  out  TAG_W  head tag
clr_sticky  in  1  synchronous clear of sticky status
ovf_sticky  out  1  set by any pushed entry with overflow
ovf_count  out  8  saturating count of pushed overflow entries

Behaviour:
- Reset (async, rst_n=0): s1_valid=0; alu_op/alu_a/alu_b=0; FIFO count, rd/wr pointers=0; ovf_sticky=0; ovf_count=0. Outputs reflect this immediately: out_valid=0, in_ready=1. In-flight requests and FIFO contents are discarded, with no partial output.
- Stage 1 (operand register): accept = in_valid && in_ready. On accept, latch op/a/b/tag and set s1_valid=1. alu_* always equal the s1 registers.
- pop = out_valid && out_ready.
- drain = s1_valid && (count<DEPTH || pop). On drain, push {alu_out, ovf, alu_out==0, alu_out[31], tag} and clear s1_valid unless a new accept happens in the same cycle.
- in_ready = !s1_valid || drain (combinational; a full FIFO with a simultaneous pop still passes).
- Overflow mask: the pushed ovf = alu_ovf only when op is ADD or SUB; it is 0 for all other ops.
- Latency: accept at edge N, push at edge N+1, out_valid=1 in the cycle after edge N+1 (2 edges). Throughput is 1 op/cycle with out_ready held high.
- FIFO: out_* are driven from head storage (no combinational path from in_* or alu_* to out_*). Pointers wrap modulo DEPTH. A push and a pop in the same cycle leave count unchanged. Order is strictly preserved.
- Full stall (count==DEPTH, !out_ready): s1 holds and alu_* stay stable. in_ready=0 only when s1_valid is also set.
- Sticky: a push with ovf=1 sets ovf_sticky and increments ovf_count, saturating at 255. clr_sticky clears both. If clr_sticky and an overflow push occur in the same cycle, the set wins: sticky=1, count=1.
- out_valid = (count!=0). Popping an empty FIFO has no effect.

Decomposition:
- Shared include alu_defs: opcode constants (ADD..OR, 3-bit), ALU_W=32.
- Instantiates nothing. The alu is connected externally via alu_* ports, so the bench can use either the real alu or a stub.
- One natural sub-module: result_fifo (parameterised DEPTH×(35+TAG_W) storage with push/pop/count).

Test Plan:
1. ADD a=-2147483000 b=1 tag=3, out_ready=1 -> 2 edges later out_result=-2147482999, ovf=0, zero=0, neg=1, tag=3.
2. ADD 0x7FFFFFFF + 1 -> out_result=0x80000000, out_ovf=1, ovf_sticky=1, ovf_count=1. Then SUB 5-5 -> zero=1, ovf=0.
3. SLT 0x80000000,1 using a stub alu forcing alu_ovf=1 -> out_result=1, out_ovf=0 (masked), ovf_count unchanged.
4. out_ready=0, four back-to-back requests -> two entries in FIFO, one held in s1 with alu_* stable, in_ready=0. Raise out_ready -> all four emerge in tag order with no loss or duplication; a pop on a full FIFO accepts in the same cycle.
5. 300 ADD overflows -> ovf_count=255. Then clr_sticky coincident with an overflow push -> ovf_sticky=1, ovf_count=1. clr_sticky alone -> both 0.
6. rst_n low asynchronously mid-cycle with FIFO holding 2 and s1 full -> out_valid=0 and in_ready=1 before the next edge. After release the first new request returns normally.
